// File: rtl/poly_osc_pkg.sv
// Shared types and default widths for the polyphonic oscillator bank.
package poly_osc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;
  typedef enum logic [1:0] {WAVE_SINE, WAVE_SAW, WAVE_SQUARE, WAVE_SILENT} wave_t;

  localparam int NUM_VOICES_DEF = 8;
  localparam int SAMPLE_W_DEF   = 16;
  localparam int VIDX_W         = $clog2(NUM_VOICES_DEF);
  localparam int ACC_W          = SAMPLE_W_DEF + VIDX_W;
endpackage

// File: rtl/osc_wave_shaper.sv
// Per-lookup waveform selector. POLY_OSC_WAVE_EN adds saw/square/silent;
// without it every lookup passes the sine ROM word through.
module osc_wave_shaper
  import poly_osc_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
`ifdef POLY_OSC_WAVE_EN
  input  wave_t                       wave,
  input  logic [SAMPLE_W-1:0]         phase_top,
`endif
  input  logic signed [SAMPLE_W-1:0]  rom_data,
  output logic signed [SAMPLE_W-1:0]  shaped
);
`ifdef POLY_OSC_WAVE_EN
  localparam logic signed [SAMPLE_W-1:0] FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};

  always_comb begin
    shaped = rom_data;
    case (wave)
      WAVE_SAW:    shaped = {~phase_top[SAMPLE_W-1], phase_top[SAMPLE_W-2:0]};
      WAVE_SQUARE: shaped = phase_top[SAMPLE_W-1] ? -FULL : FULL;
      WAVE_SILENT: shaped = '0;
      default:     ;
    endcase
  end
`else
  assign shaped = rom_data;
`endif
endmodule

// File: rtl/poly_osc_bank.sv
// Time-multiplexed N-voice phase-accumulator oscillator bank with shared sine ROM.
// Optional per-voice waveform select when POLY_OSC_WAVE_EN is defined.
module poly_osc_bank
  import poly_osc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int ADDR_W     = 12,
  parameter int SAMPLE_W   = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Sample_req,
  input  logic                          Voice_we,
  input  logic [$clog2(NUM_VOICES)-1:0] Voice_sel,
  input  logic [PHASE_W-1:0]            Voice_inc,
  input  logic                          Voice_on,
  input  logic                          Voice_prst,
`ifdef POLY_OSC_WAVE_EN
  input  logic [1:0]                    Voice_wave,
`endif
  output logic [ADDR_W-1:0]             Rom_addr,
  input  logic [SAMPLE_W-1:0]           Rom_data,
  output logic [SAMPLE_W-1:0]           Sample_out,
  output logic                          Sample_valid,
  output logic                          Busy,
  output logic                          Overrun
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int AW = SAMPLE_W + VW;

  state_t                               state;
  logic [VW-1:0]                        idx;
  logic signed [AW-1:0]                 acc;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]   phase, inc;
  logic [NUM_VOICES-1:0]                gate;
  logic                                 lk_vld, lk_gate;
  logic signed [SAMPLE_W-1:0]           shaped;

  assign Busy     = (state != IDLE);
  assign Rom_addr = (state == RUN) ? phase[idx][PHASE_W-1 -: ADDR_W] : '0;

`ifdef POLY_OSC_WAVE_EN
  wave_t [NUM_VOICES-1:0] wave;
  wave_t                  lk_wave;
  logic [SAMPLE_W-1:0]    lk_phase;

  // Shape inputs are captured alongside the ROM address so they line up with Rom_data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lk_wave  <= WAVE_SINE;
      lk_phase <= '0;
    end else if (state == RUN) begin
      lk_wave  <= wave[idx];
      lk_phase <= phase[idx][PHASE_W-1 -: SAMPLE_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wave <= '{default: WAVE_SINE};
    else if (Voice_we) wave[Voice_sel] <= wave_t'(Voice_wave);
  end

  osc_wave_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
    .wave      (lk_wave),
    .phase_top (lk_phase),
    .rom_data  (Rom_data),
    .shaped    (shaped)
  );
`else
  osc_wave_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
    .rom_data  (Rom_data),
    .shaped    (shaped)
  );
`endif

  // Voice registers: the RUN advance reads the pre-write inc; preset overrides the advance.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase <= '0;
      inc   <= '0;
      gate  <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (state == RUN && idx == VW'(v)) phase[v] <= phase[v] + inc[v];
        if (Voice_we && Voice_sel == VW'(v)) begin
          inc[v]  <= Voice_inc;
          gate[v] <= Voice_on;
          if (Voice_prst) phase[v] <= '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      lk_vld       <= 1'b0;
      lk_gate      <= 1'b0;
      Sample_out   <= '0;
      Sample_valid <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      Sample_valid <= 1'b0;
      lk_vld       <= (state == RUN);
      if (Sample_req && state != IDLE) Overrun <= 1'b1;
      // ROM data arriving this cycle belongs to the voice addressed last cycle.
      if (lk_vld && lk_gate) acc <= acc + {{VW{shaped[SAMPLE_W-1]}}, shaped};
      case (state)
        IDLE: if (Sample_req) begin
          state <= RUN;
          idx   <= '0;
          acc   <= '0;
        end
        RUN: begin
          lk_gate <= gate[idx];
          idx     <= idx + 1'b1;
          if (idx == VW'(NUM_VOICES - 1)) state <= FLUSH;
        end
        FLUSH: state <= OUT;
        OUT: begin
          Sample_out   <= SAMPLE_W'(acc >>> VW);
          Sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_osc_bank.sv
// Scoreboard bench for poly_osc_bank (4 voices); define POLY_OSC_WAVE_EN to cover wave shapes.
module tb_poly_osc_bank;
  localparam int NV = 4, PW = 24, AWD = 12, SW = 16;

  logic           Clk, Reset_n, Sample_req, Voice_we, Voice_on, Voice_prst;
  logic [1:0]     Voice_sel;
  logic [PW-1:0]  Voice_inc;
  logic [AWD-1:0] Rom_addr;
  logic [SW-1:0]  Rom_data, Sample_out;
  logic           Sample_valid, Busy, Overrun;
`ifdef POLY_OSC_WAVE_EN
  logic [1:0]     Voice_wave;
`endif

  poly_osc_bank #(.NUM_VOICES(NV), .PHASE_W(PW), .ADDR_W(AWD), .SAMPLE_W(SW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sample_req(Sample_req), .Voice_we(Voice_we),
    .Voice_sel(Voice_sel), .Voice_inc(Voice_inc), .Voice_on(Voice_on), .Voice_prst(Voice_prst),
`ifdef POLY_OSC_WAVE_EN
    .Voice_wave(Voice_wave),
`endif
    .Rom_addr(Rom_addr), .Rom_data(Rom_data), .Sample_out(Sample_out),
    .Sample_valid(Sample_valid), .Busy(Busy), .Overrun(Overrun)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Sine ROM stand-in: data is the address sign-extended, one cycle late.
  always @(posedge Clk) Rom_data <= {{(SW-AWD){Rom_addr[AWD-1]}}, Rom_addr};

  int n_checks = 0, n_errors = 0;
  int exp_addr_q[$], exp_sample_q[$];
  int unsigned m_phase[NV], m_inc[NV];
  bit  m_gate[NV];
  int  m_wave[NV];
  bit  abort_next = 0, frame_skip = 0;
  int  frame_age = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shape(input int w, input int unsigned ph);
    int a;
    a = int'(ph >> 12);
    case (w)
      1: return int'(ph >> 8) - 32768;            // saw ramps from -32768 upward
      2: return (ph >= 32'h800000) ? -32767 : 32767;
      3: return 0;
      default: return (a >= 2048) ? a - 4096 : a;
    endcase
  endfunction

  // Reference: one frame = every voice looked up at its current phase, then advanced.
  task automatic model_frame();
    int sum, q;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      exp_addr_q.push_back(int'(m_phase[v] >> 12));
      if (m_gate[v]) sum += shape(m_wave[v], m_phase[v]);
      m_phase[v] = (m_phase[v] + m_inc[v]) & 32'hFFFFFF;
    end
    q = sum / NV;
    if (sum < 0 && (sum % NV) != 0) q -= 1;
    exp_sample_q.push_back(q);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0; m_inc[v] = 0; m_gate[v] = 0; m_wave[v] = 0;
    end
  endtask

  task automatic write_voice(input int v, input int unsigned incw, input bit on, input bit prst, input int w);
    @(posedge Clk); #1;
    Voice_we = 1; Voice_sel = 2'(v); Voice_inc = PW'(incw); Voice_on = on; Voice_prst = prst;
`ifdef POLY_OSC_WAVE_EN
    Voice_wave = 2'(w);
    m_wave[v] = w;
`else
    m_wave[v] = 0 * w;
`endif
    @(posedge Clk); #1;
    Voice_we = 0; Voice_prst = 0;
    m_inc[v] = incw; m_gate[v] = on;
    if (prst) m_phase[v] = 0;
  endtask

  task automatic do_frame();
    model_frame();
    @(posedge Clk); #1 Sample_req = 1;
    @(posedge Clk); #1 Sample_req = 0;
    repeat (NV + 4) @(posedge Clk);
  endtask

  // Monitor: tracks each accepted frame, checks ROM addresses and valid timing/value.
  always @(negedge Clk) begin
    if (!Reset_n) frame_age = -1;
    else if (frame_age < 0) begin
      if (Sample_valid) check("unexpected_valid", int'(Sample_valid), 0);
      if (Sample_req && !Busy) begin
        frame_age  = 0;
        frame_skip = abort_next;
      end
    end else begin
      frame_age++;
      if (frame_skip) begin
        if (frame_age > NV + 3) frame_age = -1;
      end else begin
        if (frame_age >= 1 && frame_age <= NV) begin
          if (exp_addr_q.size() == 0) check("addr_queue_underflow", 0, 1);
          else check("rom_addr", int'(Rom_addr), exp_addr_q.pop_front());
        end
        if (frame_age == NV + 3) begin
          check("valid_latency", int'(Sample_valid), 1);
          if (Sample_valid) begin
            if (exp_sample_q.size() == 0) check("sample_queue_underflow", 0, 1);
            else check("sample_out", int'($signed(Sample_out)), exp_sample_q.pop_front());
          end
          frame_age = -1;
        end else if (Sample_valid) check("early_valid", int'(Sample_valid), 0);
      end
    end
  end

  initial begin
    Reset_n = 0; Sample_req = 0; Voice_we = 0; Voice_sel = 0; Voice_inc = 0;
    Voice_on = 0; Voice_prst = 0;
`ifdef POLY_OSC_WAVE_EN
    Voice_wave = 0;
`endif
    model_reset();

    // Reset state
    repeat (20) @(posedge Clk);
    #1 Reset_n = 1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rom_addr", int'(Rom_addr), 0);
    check("rst_sample_out", int'(Sample_out), 0);
    check("rst_valid", int'(Sample_valid), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_overrun", int'(Overrun), 0);

    // Reset mid-RUN aborts the frame
    write_voice(0, 32'h100000, 1, 0, 0);
    abort_next = 1;
    @(posedge Clk); #1 Sample_req = 1;
    @(posedge Clk); #1 Sample_req = 0;
    @(posedge Clk); #1 check("busy_midrun", int'(Busy), 1);
    Reset_n = 0;
    #1 check("busy_async_clear", int'(Busy), 0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1; abort_next = 0;
    model_reset();
    repeat (NV + 4) @(posedge Clk);
    #1 check("abort_sample_out", int'(Sample_out), 0);

    // Single voice ramp: addresses 0,16,32 -> samples 0,4,8
    write_voice(0, 32'h010000, 1, 1, 0);
    repeat (3) do_frame();

    // Negative sums: exact and non-exact floor division
    write_voice(0, 32'hFFF000, 1, 1, 0);
    do_frame();
    do_frame();
    for (int v = 0; v < NV; v++) write_voice(v, 32'h900000, 1, 1, 0);
    do_frame();
    do_frame();
    write_voice(2, 32'h300000, 0, 0, 0);
    do_frame();

    // Randomized writes between frames
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++)
        write_voice(int'($urandom_range(NV - 1, 0)), $urandom & 32'hFFFFFF,
                    bit'($urandom_range(3, 0) != 0), bit'($urandom_range(3, 0) == 0),
                    int'($urandom_range(3, 0)));
      do_frame();
    end

    // Write with preset on voice 1 during its own RUN slot
    write_voice(1, 32'h123000, 1, 1, 0);
    do_frame();
    model_frame();
    @(posedge Clk); #1 Sample_req = 1;
    @(posedge Clk); #1 Sample_req = 0;
    @(posedge Clk); #1 Voice_we = 1; Voice_sel = 2'd1; Voice_inc = 24'h456000;
    Voice_on = 1; Voice_prst = 1;
    @(posedge Clk); #1 Voice_we = 0; Voice_prst = 0;
    repeat (NV + 3) @(posedge Clk);
    m_phase[1] = 0; m_inc[1] = 32'h456000; m_gate[1] = 1;
    do_frame();
    do_frame();

`ifdef POLY_OSC_WAVE_EN
    for (int v = 1; v < NV; v++) write_voice(v, 0, 0, 1, 0);
    write_voice(0, 32'h800000, 1, 1, 1);
    do_frame();
    do_frame();
    write_voice(0, 32'h800000, 1, 1, 2);
    do_frame();
    do_frame();
    write_voice(0, 32'h123456, 1, 1, 3);
    do_frame();
`endif

    // Overrun: second request two clocks after the first
    model_frame();
    @(posedge Clk); #1 Sample_req = 1;
    @(posedge Clk); #1 Sample_req = 0;
    @(posedge Clk); #1 Sample_req = 1;
    @(posedge Clk); #1 Sample_req = 0;
    repeat (NV + 4) @(posedge Clk);
    #1 check("overrun_set", int'(Overrun), 1);
    do_frame();
    do_frame();
    #1 check("overrun_sticky", int'(Overrun), 1);

    // Drain with a bounded wait
    for (int t = 0; t < 50 && (exp_sample_q.size() != 0 || frame_age >= 0); t++) @(posedge Clk);
    check("drain_samples", exp_sample_q.size(), 0);
    check("drain_addrs", exp_addr_q.size(), 0);

    @(posedge Clk); #1 Reset_n = 0;
    #1 check("overrun_reset", int'(Overrun), 0);
    #10 Reset_n = 1;
    repeat (2) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
